// File: rtl/instr_queue.sv
// instr_queue: FWFT circular instruction buffer (enq_*/deq_* handshakes, flush, count), no empty-bypass
module instr_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_inst,
  input  logic [31:0]              enq_pc,
  input  logic [63:0]              enq_order,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [31:0]              deq_inst,
  output logic [31:0]              deq_pc,
  output logic [63:0]              deq_order,
  input  logic                     deq_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] head, tail;
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [63:0] order_mem [DEPTH];
  logic empty, full, enq_fire, deq_fire;
  always_comb begin
    empty = head == tail;
    full = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    enq_ready = !full && !flush;
    deq_valid = !empty && !flush;
    enq_fire = enq_valid && enq_ready;
    deq_fire = deq_valid && deq_ready;
    count = tail - head;
    deq_inst = deq_valid ? inst_mem[head[AW-1:0]] : '0;
    deq_pc = deq_valid ? pc_mem[head[AW-1:0]] : '0;
    deq_order = deq_valid ? order_mem[head[AW-1:0]] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_fire) tail <= tail + ONE;
      if (deq_fire) head <= head + ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      inst_mem[tail[AW-1:0]] <= enq_inst;
      pc_mem[tail[AW-1:0]] <= enq_pc;
      order_mem[tail[AW-1:0]] <= enq_order;
    end
  end
endmodule
